// File: rtl/serial_word_feeder.sv
// Serial word feeder: takes a parallel word over valid/ready and emits it one bit per clock as a
// framed stream, then publishes the word's ones-count and parity for the downstream detector.
module serial_word_feeder #(
   parameter int WIDTH      = 8,
   parameter int GAP_CYCLES = 1,
   parameter bit MSB_FIRST  = 1'b1,
   localparam int CW        = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             frame_start,
   output logic             frame_end,
   output logic             result_valid,
   output logic [CW-1:0]    ones_count,
   output logic             parity_odd
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t           state_r,        state_s;
   logic [WIDTH-1:0] shreg_r,        shreg_s;
   logic [CNT_W-1:0] bit_cnt_r,      bit_cnt_s;
   logic [3:0]       gap_cnt_r,      gap_cnt_s;
   logic [CW-1:0]    ones_acc_r,     ones_acc_s;
   logic [CW-1:0]    ones_sum_s;
   logic             load_ready_r,   load_ready_s;
   logic             bit_out_r,      bit_out_s;
   logic             bit_valid_r,    bit_valid_s;
   logic             frame_start_r,  frame_start_s;
   logic             frame_end_r,    frame_end_s;
   logic             result_valid_r, result_valid_s;
   logic [CW-1:0]    ones_count_r,   ones_count_s;
   logic             parity_odd_r,   parity_odd_s;

   function automatic logic head_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
   endfunction

   function automatic logic count_is_odd(input logic [CW-1:0] n);
      return n[0];
   endfunction

   // Next-state and next-output decode; every output is registered one edge ahead of its bit.
   always_comb begin
      state_s        = state_r;
      shreg_s        = shreg_r;
      bit_cnt_s      = bit_cnt_r;
      gap_cnt_s      = gap_cnt_r;
      ones_acc_s     = ones_acc_r;
      bit_out_s      = 1'b0;
      bit_valid_s    = 1'b0;
      frame_start_s  = 1'b0;
      frame_end_s    = 1'b0;
      result_valid_s = 1'b0;
      ones_count_s   = ones_count_r;
      parity_odd_s   = parity_odd_r;
      ones_sum_s     = ones_acc_r + {{(CW-1){1'b0}}, bit_out_r};

      case (state_r)
         ST_IDLE: begin
            if (load_valid) begin
               state_s       = ST_SHIFT;
               shreg_s       = load_data;
               bit_cnt_s     = {CNT_W{1'b0}};
               ones_acc_s    = {CW{1'b0}};
               bit_out_s     = head_bit(load_data);
               bit_valid_s   = 1'b1;
               frame_start_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (bit_cnt_r == CNT_W'(WIDTH - 1)) begin
               // Last bit leaves the line on this edge: publish the finished word's statistics.
               ones_count_s   = ones_sum_s;
               parity_odd_s   = count_is_odd(ones_sum_s);
               result_valid_s = 1'b1;
               ones_acc_s     = {CW{1'b0}};
               gap_cnt_s      = 4'd0;
               state_s        = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            end else begin
               ones_acc_s  = ones_sum_s;
               shreg_s     = shift_word(shreg_r);
               bit_cnt_s   = bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
               bit_out_s   = head_bit(shift_word(shreg_r));
               bit_valid_s = 1'b1;
               frame_end_s = (bit_cnt_r == CNT_W'(WIDTH - 2));
            end
         end
         ST_GAP: begin
            if (gap_cnt_r == 4'(GAP_CYCLES - 1)) begin
               state_s = ST_IDLE;
            end else begin
               gap_cnt_s = gap_cnt_r + 4'd1;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      load_ready_s = (state_s == ST_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= ST_IDLE;
         shreg_r        <= {WIDTH{1'b0}};
         bit_cnt_r      <= {CNT_W{1'b0}};
         gap_cnt_r      <= 4'd0;
         ones_acc_r     <= {CW{1'b0}};
         load_ready_r   <= 1'b1;
         bit_out_r      <= 1'b0;
         bit_valid_r    <= 1'b0;
         frame_start_r  <= 1'b0;
         frame_end_r    <= 1'b0;
         result_valid_r <= 1'b0;
         ones_count_r   <= {CW{1'b0}};
         parity_odd_r   <= 1'b0;
      end else begin
         state_r        <= state_s;
         shreg_r        <= shreg_s;
         bit_cnt_r      <= bit_cnt_s;
         gap_cnt_r      <= gap_cnt_s;
         ones_acc_r     <= ones_acc_s;
         load_ready_r   <= load_ready_s;
         bit_out_r      <= bit_out_s;
         bit_valid_r    <= bit_valid_s;
         frame_start_r  <= frame_start_s;
         frame_end_r    <= frame_end_s;
         result_valid_r <= result_valid_s;
         ones_count_r   <= ones_count_s;
         parity_odd_r   <= parity_odd_s;
      end
   end

   assign load_ready   = load_ready_r;
   assign bit_out      = bit_out_r;
   assign bit_valid    = bit_valid_r;
   assign frame_start  = frame_start_r;
   assign frame_end    = frame_end_r;
   assign result_valid = result_valid_r;
   assign ones_count   = ones_count_r;
   assign parity_odd   = parity_odd_r;

endmodule
